// File: rtl/code_decoder_fifo.sv
// Small FIFO of CW-bit codes that presents the head entry as a one-hot vector.
// Also keeps a sticky mask of every code accepted since the last clear.
module code_decoder_fifo #(
  parameter  int CW    = 3,
  parameter  int DEPTH = 4,
  localparam int OW    = 2 ** CW,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] code,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out_onehot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] count,
  output logic [OW-1:0] seen,
  input  logic          clr_seen
);

  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  function automatic logic [OW-1:0] decode(input logic [CW-1:0] c);
    logic [OW-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Handshake qualifiers depend on registered count only, never on valid/ready inputs.
  assign in_ready  = (count != NW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_onehot = '0;
    if (out_valid) out_onehot = decode(mem[rd_ptr]);
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear colliding with a push keeps only the newly accepted code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen <= '0;
    end else if (push) begin
      seen <= (clr_seen ? '0 : seen) | decode(code);
    end else if (clr_seen) begin
      seen <= '0;
    end
  end

endmodule

// File: tb/tb_code_decoder_fifo.sv
// Directed bench for code_decoder_fifo: a queue-based reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_code_decoder_fifo;

  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int OW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] code;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_onehot;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    count;
  logic [OW-1:0] seen;
  logic          clr_seen;

  int n_cmp = 0;
  int n_bad = 0;

  code_decoder_fifo #(.CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .code(code), .in_valid(in_valid), .in_ready(in_ready),
    .out_onehot(out_onehot), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .seen(seen), .clr_seen(clr_seen)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of codes and a sticky mask.
  logic [CW-1:0] q[$];
  logic [OW-1:0] m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_seen = '0;
    end else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (q.size() > 0);
      automatic logic [CW-1:0] c = code;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(c);
        m_seen = (clr_seen ? 8'h00 : m_seen) | (8'h01 << c);
      end else if (clr_seen) begin
        m_seen = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic logic [OW-1:0] exp_oh = (q.size() > 0) ? (8'h01 << q[0]) : 8'h00;
    chk("model_count",  32'(count),      32'(q.size()));
    chk("model_ready",  32'(in_ready),   32'(q.size() < DEPTH));
    chk("model_valid",  32'(out_valid),  32'(q.size() > 0));
    chk("model_onehot", 32'(out_onehot), 32'(exp_oh));
    chk("model_seen",   32'(seen),       32'(m_seen));
  end

  // Drive inputs just after a rising edge, then advance through the next edge.
  task automatic cyc(input logic iv, input logic [CW-1:0] c, input logic ordy, input logic clr);
    in_valid  = iv;
    code      = c;
    out_ready = ordy;
    clr_seen  = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_seen  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; code = '0; in_valid = 1'b0; out_ready = 1'b0; clr_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-cycle with three entries buffered.
    cyc(1, 3'd1, 0, 0);
    cyc(1, 3'd2, 0, 0);
    cyc(1, 3'd4, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("reset_count",  32'(count),      32'd0);
    chk("reset_valid",  32'(out_valid),  32'd0);
    chk("reset_onehot", 32'(out_onehot), 32'h00);
    chk("reset_seen",   32'(seen),       32'h00);
    chk("reset_ready",  32'(in_ready),   32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single push of code 5.
    cyc(1, 3'd5, 0, 0);
    chk("single_valid",  32'(out_valid),  32'd1);
    chk("single_onehot", 32'(out_onehot), 32'h20);
    chk("single_count",  32'(count),      32'd1);
    chk("single_seen",   32'(seen),       32'h20);
    cyc(0, 3'd0, 1, 0);
    cyc(0, 3'd0, 0, 1);

    // Fill, blocked push with pop, then drain.
    cyc(1, 3'd0, 0, 0);
    cyc(1, 3'd7, 0, 0);
    cyc(1, 3'd3, 0, 0);
    cyc(1, 3'd3, 0, 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count),    32'd4);
    cyc(1, 3'd1, 1, 0);
    chk("blocked_count", 32'(count), 32'd3);
    chk("drain_oh0", 32'(out_onehot), 32'h80);
    cyc(0, 3'd0, 1, 0);
    chk("drain_oh1", 32'(out_onehot), 32'h08);
    cyc(0, 3'd0, 1, 0);
    chk("drain_oh2", 32'(out_onehot), 32'h08);
    cyc(0, 3'd0, 1, 0);
    chk("drained_count", 32'(count), 32'd0);
    chk("drain_seen",    32'(seen),  32'h89);

    // Steady push+pop at occupancy 2; pointers wrap several times.
    cyc(1, 3'd6, 0, 0);
    cyc(1, 3'd2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 3'((i * 3) % 8), 1, 0);
      chk("stream_count", 32'(count), 32'd2);
    end
    // Head now holds the 9th streamed code: (8*3)%8 = 0.
    chk("stream_head", 32'(out_onehot), 32'h01);
    cyc(0, 3'd0, 1, 0);
    cyc(0, 3'd0, 1, 0);

    // Cover all codes so seen saturates, then clear collisions.
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 1, 0);
    cyc(0, 3'd0, 1, 0);
    chk("all_seen", 32'(seen), 32'hFF);
    cyc(1, 3'd2, 1, 1);
    chk("clr_push_seen", 32'(seen), 32'h04);
    cyc(0, 3'd0, 1, 1);
    chk("clr_only_seen", 32'(seen), 32'h00);

    // Undriven code while idle must leave everything untouched.
    cyc(1, 3'd6, 0, 0);
    cyc(0, 3'bxxx, 0, 0);
    chk("x_count",  32'(count),      32'd1);
    chk("x_seen",   32'(seen),       32'h40);
    chk("x_onehot", 32'(out_onehot), 32'h40);
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_decoder_fifo.md
# code_decoder_fifo

Inverse of the team's 8-input priority encoder. Accepts a stream of 3-bit codes over a valid/ready handshake, buffers them in a small FIFO, and presents each one as an 8-bit one-hot vector over a second valid/ready handshake. It also keeps a sticky mask of every code accepted since the last clear. It sits downstream of the encoder, so that any consumer that needs the one-hot form can rebuild the original request line at its own pace.

## Interface
Parameters:
- `CW`, 3, code width; the one-hot width is `OW = 2**CW` (8).
- `DEPTH`, 4, FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `code`  input  CW  code to decode; ignored, and may be X, when `in_valid` = 0.
- `in_valid`  input  1  `code` is presented.
- `in_ready`  output  1  FIFO can accept; equals `count != DEPTH`.
- `out_onehot`  output  OW  `1 << head_code` when `out_valid` = 1, else all zeros.
- `out_valid`  output  1  FIFO non-empty; equals `count != 0`.
- `out_ready`  input  1  consumer takes the head entry.
- `count`  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `seen`  output  OW  sticky OR of the one-hot form of every accepted code.
- `clr_seen`  input  1  synchronous clear of `seen`.

## Operation
- Push: `in_valid && in_ready` at a rising edge. `code` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop: `out_valid && out_ready` at a rising edge. `rd_ptr` increments modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Full (`count == DEPTH`): `in_ready` = 0. No push occurs even if a pop happens in the same cycle; there is no full-bypass.
- Empty (`count == 0`): `out_valid` = 0 and `out_onehot` = 0. There is no empty-bypass; a code pushed into an empty FIFO cannot be popped in the same cycle.
- Decode: `out_onehot` is combinational from storage, `out_onehot[mem[rd_ptr]] = 1` and every other bit is 0. Exactly one bit is set whenever `out_valid` = 1.
- `seen` register:
  - On a push, `seen <= seen | (1 << code)`.
  - With `clr_seen` = 1 and no push: `seen <= 0`.
  - With `clr_seen` = 1 and a push in the same cycle: `seen <= (1 << code)`; the clear applies first, then the new code is recorded.
  - Pops do not affect `seen`.
- Pointers wrap silently. Full and empty are distinguished only by `count`.
- Asserting `rst` mid-operation drops all buffered entries immediately. Storage contents are don't-care after reset.

## Timing
- Reset values, applied asynchronously while `rst` = 1:
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0, `seen` = 0
  - therefore `in_ready` = 1, `out_valid` = 0, `out_onehot` = 0.
- Latency: a code pushed at edge N is visible on `out_onehot` and `out_valid` after edge N, provided it is at the head. That is one cycle.
- Throughput: one push and one pop per cycle sustained. A full FIFO with `out_ready` = 1 frees one slot per cycle.
- `in_ready` and `out_valid` are functions of registered `count` only. There is no combinational path from `in_valid` or `out_ready` to them.
- Order is strict FIFO. A given code may appear multiple times; entries are not deduplicated.
- Deassertion of `rst` is assumed synchronous to `clk` (handled by the top-level reset synchronizer).

## Test plan
- **Reset:** assert `rst` mid-cycle with `count` = 3.
  - Required: `count` = 0, `out_valid` = 0, `out_onehot` = 8'h00, `seen` = 8'h00 and `in_ready` = 1 immediately, without waiting for an edge.
- **Single push:** push `code` = 3'd5 into an empty FIFO with `out_ready` = 0.
  - Required one edge later: `out_valid` = 1, `out_onehot` = 8'h20, `count` = 1, `seen` = 8'h20.
- **Fill and drain:** push codes 0, 7, 3, 3 with `out_ready` = 0.
  - Required after the 4th push: `in_ready` = 0, `count` = 4.
  - Then drive a 5th push (`code` 1) with `out_ready` = 1 in the same cycle. Required: `count` = 3 and code 1 not stored.
  - Then drain. Required `out_onehot` sequence: 8'h80, 8'h08, 8'h08; `seen` = 8'h89.
- **Simultaneous push and pop:** with `count` = 2, drive a push and a pop every cycle for 10 cycles.
  - Required: `count` stays 2 throughout, pointers wrap past DEPTH, output order matches input order.
- **Clear collision:** with `seen` = 8'hFF, assert `clr_seen` together with a push of `code` = 3'd2.
  - Required: `seen` = 8'h04.
  - Then assert `clr_seen` alone. Required: `seen` = 8'h00.
- **X tolerance:** drive `code` = 3'bxxx with `in_valid` = 0.
  - Required: no change to `count`, `seen` or the outputs.
